bcd_to_decimal_dec_seq: RTL and testbench

- Sequential BCD-to-decimal decoder: the receive-side partner of the team's decimal-to-BCD encoder.
- Accepts a packed multi-digit BCD word through a valid/ready handshake.
- Emits one digit per handshake, most-significant digit first, as a 10-line one-hot decimal code. Digit index, last-digit flag and invalid-code error travel with each digit.
- Sits between BCD producers (encoders, counters) and one-hot display or indicator logic.

---
 rtl/bcd_to_decimal_dec_seq.sv | 142 ++++++++++++++
 tb/tb_bcd_to_decimal_dec_seq.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/bcd_to_decimal_dec_seq.sv
// Sequential BCD-to-decimal decoder: accepts a packed BCD word and emits one one-hot digit
// per handshake, MSD first. 1-cycle latency from accept to first digit; holds under out_ready=0.
module bcd_to_decimal_dec_seq #(
    parameter int DIGITS = 4,
    parameter int IDXW   = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4*DIGITS-1:0] bcd_in,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [9:0]          dec_out,
    output logic [IDXW-1:0]     digit_idx,
    output logic                out_last,
    output logic                out_err,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [7:0]          err_count
);

    localparam int W = 4 * DIGITS;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_shift;
    logic [9:0]      r_dec;
    logic [IDXW-1:0] r_idx;
    logic            r_last;
    logic            r_err;
    logic            r_vld;
    logic            r_rdy;
    logic [7:0]      r_cnt;

    state_t          w_state_nxt;
    logic [W-1:0]    w_shift_nxt;
    logic [9:0]      w_dec_nxt;
    logic [IDXW-1:0] w_idx_nxt;
    logic            w_last_nxt;
    logic            w_err_nxt;
    logic            w_vld_nxt;
    logic            w_rdy_nxt;
    logic [7:0]      w_cnt_nxt;

    logic [W-1:0]    w_shift_dn;
    logic [3:0]      w_digit_dn;
    logic [3:0]      w_msd_in;

    function automatic logic [9:0] decode(input logic [3:0] v);
        if (v < 4'd10) decode = 10'd1 << v;
        else           decode = 10'd0;
    endfunction

    // The shift register keeps the current digit in its top nibble.
    assign w_shift_dn = r_shift << 4;
    assign w_digit_dn = w_shift_dn[W-1 -: 4];
    assign w_msd_in   = bcd_in[W-1 -: 4];

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_dec_nxt   = r_dec;
        w_idx_nxt   = r_idx;
        w_last_nxt  = r_last;
        w_err_nxt   = r_err;
        w_vld_nxt   = r_vld;
        w_rdy_nxt   = r_rdy;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = ST_EMIT;
                    w_shift_nxt = bcd_in;
                    w_dec_nxt   = decode(w_msd_in);
                    w_err_nxt   = (w_msd_in > 4'd9);
                    w_idx_nxt   = IDXW'(DIGITS - 1);
                    w_last_nxt  = (DIGITS == 1);
                    w_vld_nxt   = 1'b1;
                    w_rdy_nxt   = 1'b0;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    if (r_err && (r_cnt != 8'hFF)) w_cnt_nxt = r_cnt + 8'd1;
                    if (r_last) begin
                        w_state_nxt = ST_IDLE;
                        w_shift_nxt = '0;
                        w_dec_nxt   = 10'd0;
                        w_err_nxt   = 1'b0;
                        w_idx_nxt   = '0;
                        w_last_nxt  = 1'b0;
                        w_vld_nxt   = 1'b0;
                        w_rdy_nxt   = 1'b1;
                    end else begin
                        w_shift_nxt = w_shift_dn;
                        w_dec_nxt   = decode(w_digit_dn);
                        w_err_nxt   = (w_digit_dn > 4'd9);
                        w_idx_nxt   = r_idx - IDXW'(1);
                        w_last_nxt  = (r_idx == IDXW'(1));
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_dec   <= 10'd0;
            r_idx   <= '0;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
            r_vld   <= 1'b0;
            r_rdy   <= 1'b1;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_dec   <= w_dec_nxt;
            r_idx   <= w_idx_nxt;
            r_last  <= w_last_nxt;
            r_err   <= w_err_nxt;
            r_vld   <= w_vld_nxt;
            r_rdy   <= w_rdy_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign in_ready  = r_rdy;
    assign out_valid = r_vld;
    assign dec_out   = r_dec;
    assign digit_idx = r_idx;
    assign out_last  = r_last;
    assign out_err   = r_err;
    assign err_count = r_cnt;

endmodule

// File: tb/tb_bcd_to_decimal_dec_seq.sv
// Directed bench for bcd_to_decimal_dec_seq with DIGITS=4: decode, backpressure,
// invalid codes, error-counter saturation and mid-word reset.
module tb_bcd_to_decimal_dec_seq;

    logic        clk;
    logic        rst;
    logic [15:0] bcd_in;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  dec_out;
    logic [2:0]  digit_idx;
    logic        out_last;
    logic        out_err;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  err_count;

    int n_total = 0;
    int n_bad   = 0;

    bcd_to_decimal_dec_seq #(.DIGITS(4), .IDXW(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .bcd_in    (bcd_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dec_out   (dec_out),
        .digit_idx (digit_idx),
        .out_last  (out_last),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input string tag, input logic [15:0] w);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        bcd_in   = w;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        bcd_in   = 16'hxxxx;
    endtask

    // Checks the digit currently presented, then lets it be accepted (out_ready=1).
    task automatic digit(input string tag, input logic [9:0] e_dec, input logic [2:0] e_idx,
                         input logic e_last, input logic e_err);
        chk({tag, ".vld"},  32'(out_valid), 32'd1);
        chk({tag, ".dec"},  32'(dec_out),   32'(e_dec));
        chk({tag, ".idx"},  32'(digit_idx), 32'(e_idx));
        chk({tag, ".last"}, 32'(out_last),  32'(e_last));
        chk({tag, ".err"},  32'(out_err),   32'(e_err));
        chk({tag, ".rdy"},  32'(in_ready),  32'd0);
        out_ready = 1'b1;
        tick();
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, ".in_ready"},  32'(in_ready),  32'd1);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        bcd_in    = 16'h0000;
        #1;
        rst = 1'b1;
        #1;
        // Asynchronous reset takes effect before any clock edge.
        chk("rst.in_ready",  32'(in_ready),  32'd1);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.dec",       32'(dec_out),   32'd0);
        chk("rst.idx",       32'(digit_idx), 32'd0);
        chk("rst.err_count", 32'(err_count), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        idle_chk("idle");

        send("w2905", 16'h2905);
        digit("w2905.d3", 10'h004, 3'd3, 1'b0, 1'b0);
        digit("w2905.d2", 10'h200, 3'd2, 1'b0, 1'b0);
        digit("w2905.d1", 10'h001, 3'd1, 1'b0, 1'b0);
        digit("w2905.d0", 10'h020, 3'd0, 1'b1, 1'b0);
        idle_chk("w2905.after");

        out_ready = 1'b0;
        send("w1234", 16'h1234);
        for (int i = 0; i < 5; i++) begin
            chk("bp.vld", 32'(out_valid), 32'd1);
            chk("bp.dec", 32'(dec_out),   32'h002);
            chk("bp.idx", 32'(digit_idx), 32'd3);
            chk("bp.rdy", 32'(in_ready),  32'd0);
            bcd_in   = 16'h9999;
            in_valid = (i % 2) == 0;
            tick();
        end
        in_valid = 1'b0;
        digit("w1234.d3", 10'h002, 3'd3, 1'b0, 1'b0);
        digit("w1234.d2", 10'h004, 3'd2, 1'b0, 1'b0);
        digit("w1234.d1", 10'h008, 3'd1, 1'b0, 1'b0);
        digit("w1234.d0", 10'h010, 3'd0, 1'b1, 1'b0);
        idle_chk("w1234.after");
        chk("w1234.err_count", 32'(err_count), 32'd0);

        send("wA3F0", 16'hA3F0);
        digit("wA3F0.d3", 10'h000, 3'd3, 1'b0, 1'b1);
        digit("wA3F0.d2", 10'h008, 3'd2, 1'b0, 1'b0);
        digit("wA3F0.d1", 10'h000, 3'd1, 1'b0, 1'b1);
        digit("wA3F0.d0", 10'h001, 3'd0, 1'b1, 1'b0);
        chk("wA3F0.err_count", 32'(err_count), 32'd2);

        // 2 + 4*63 = 254 just before saturation; 2 + 4*70 would wrap without it.
        for (int n = 0; n < 70; n++) begin
            send("sat", 16'hFFFF);
            for (int d = 0; d < 4; d++) begin
                chk("sat.err", 32'(out_err), 32'd1);
                tick();
            end
            if (n == 62) chk("sat.254", 32'(err_count), 32'd254);
            if (n == 63) chk("sat.255", 32'(err_count), 32'd255);
        end
        chk("sat.final", 32'(err_count), 32'd255);
        idle_chk("sat.after");

        send("w5678", 16'h5678);
        digit("w5678.d3", 10'h020, 3'd3, 1'b0, 1'b0);
        digit("w5678.d2", 10'h040, 3'd2, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst.in_ready",  32'(in_ready),  32'd1);
        chk("midrst.out_valid", 32'(out_valid), 32'd0);
        chk("midrst.dec",       32'(dec_out),   32'd0);
        chk("midrst.idx",       32'(digit_idx), 32'd0);
        chk("midrst.err_count", 32'(err_count), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        send("w0001", 16'h0001);
        digit("w0001.d3", 10'h001, 3'd3, 1'b0, 1'b0);
        digit("w0001.d2", 10'h001, 3'd2, 1'b0, 1'b0);
        digit("w0001.d1", 10'h001, 3'd1, 1'b0, 1'b0);
        digit("w0001.d0", 10'h002, 3'd0, 1'b1, 1'b0);
        idle_chk("w0001.after");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
